// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT_LOAD,
    SETUP,
    PULSE,
    HOLD,
    IDLE
  } lcd_state_t;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_FUNC_2L = 8'h38;
  localparam logic [7:0] CMD_FUNC_1L = 8'h30;

  localparam int unsigned INIT_LEN = 4;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] init_byte(input logic [2:0] idx, input logic two_line,
                                           input logic [7:0] disp_ctrl);
    case (idx)
      3'd0:    init_byte = two_line ? CMD_FUNC_2L : CMD_FUNC_1L;
      3'd1:    init_byte = disp_ctrl;
      3'd2:    init_byte = CMD_ENTRY;
      default: init_byte = CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module lcd_cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// LCD write controller: power-up wait, fixed init sequence, then user writes
// each framed as SETUP / enable PULSE / HOLD.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC    = 750000,
  parameter int unsigned EN_PULSE_CYC   = 25,
  parameter int unsigned CMD_WAIT_CYC   = 2500,
  parameter int unsigned CLEAR_WAIT_CYC = 82000,
  parameter bit          TWO_LINE       = 1'b1,
  parameter logic [7:0]  DISP_CTRL      = 8'h0C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int unsigned CW = $clog2(max2(max2(POWERUP_CYC, EN_PULSE_CYC),
                                           max2(CMD_WAIT_CYC, CLEAR_WAIT_CYC))) + 1;
  localparam logic [CW-1:0] PWR_LD   = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(EN_PULSE_CYC - 1);
  localparam logic [CW-1:0] CMD_LD   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_LD   = CW'(CLEAR_WAIT_CYC - 1);
  localparam logic [2:0]    INIT_LAST = 3'(INIT_LEN);

  lcd_state_t    state;
  logic [2:0]    idx;
  logic          armed;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;
  logic          long_wait;

  assign long_wait = !lcd_rs && (lcd_data == CMD_CLEAR || lcd_data == CMD_HOME);

  // The counter is zero out of reset, so PWRUP spends one arming cycle loading it.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      PWRUP: begin
        if (!armed) begin
          tmr_load = 1'b1;
          tmr_val  = PWR_LD;
        end
      end
      SETUP: begin
        tmr_load = 1'b1;
        tmr_val  = PULSE_LD;
      end
      PULSE: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = long_wait ? CLR_LD : CMD_LD;
        end
      end
      default: ;
    endcase
  end

  lcd_cycle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PWRUP;
      armed     <= 1'b0;
      idx       <= '0;
      init_done <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_data  <= '0;
    end else begin
      unique case (state)
        PWRUP: begin
          if (!armed) armed <= 1'b1;
          else if (tmr_done) state <= INIT_LOAD;
        end
        INIT_LOAD: begin
          lcd_rs   <= 1'b0;
          lcd_data <= init_byte(idx, TWO_LINE, DISP_CTRL);
          idx      <= idx + 3'd1;
          state    <= SETUP;
        end
        SETUP: begin
          lcd_en <= 1'b1;
          state  <= PULSE;
        end
        PULSE: begin
          if (tmr_done) begin
            lcd_en <= 1'b0;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (tmr_done) begin
            if (init_done) begin
              state <= IDLE;
            end else if (idx == INIT_LAST) begin
              state     <= IDLE;
              init_done <= 1'b1;
            end else begin
              state <= INIT_LOAD;
            end
          end
        end
        IDLE: begin
          if (req_valid && init_done) begin
            lcd_rs   <= req_rs;
            lcd_data <= req_data;
            state    <= SETUP;
          end
        end
        default: state <= PWRUP;
      endcase
    end
  end

  assign req_ready = (state == IDLE) && init_done;
  assign busy      = (state != IDLE);
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: expected writes are queued at issue time and
// matched against each enable pulse, its length, and the time until idle.
module tb_lcd_ctrl;

  localparam int unsigned POWERUP = 20;
  localparam int unsigned EN      = 4;
  localparam int unsigned CMDW    = 10;
  localparam int unsigned CLRW    = 50;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    bit         init;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = '0;
  logic       init_done, busy, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  int    vectors = 0;
  int    miscompares = 0;
  item_t q[$];

  always #5 clk = ~clk;

  lcd_ctrl #(
    .POWERUP_CYC    (POWERUP),
    .EN_PULSE_CYC   (EN),
    .CMD_WAIT_CYC   (CMDW),
    .CLEAR_WAIT_CYC (CLRW),
    .TWO_LINE       (1'b1),
    .DISP_CTRL      (8'h0C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .init_done (init_done),
    .busy      (busy),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait after the enable pulse, from the LCD command rules.
  function automatic int wait_of(input item_t it);
    return (!it.rs && (it.data == 8'h01 || it.data == 8'h02)) ? CLRW : CMDW;
  endfunction

  // Monitor: pulse rise pops an expected write; completion time is checked
  // either at the next rise (init chain) or when the controller goes idle.
  int    since, hi, rise_at, exp_lat;
  bit    in_pulse, track, have, first_seen;
  item_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      since = 0; in_pulse = 0; track = 0; have = 0; first_seen = 0; hi = 0;
    end else begin
      since++;
      if (lcd_en && !in_pulse) begin
        if (track) begin
          chk("init_gap", since - rise_at - 1, exp_lat);
          track = 0;
        end
        if (!first_seen) begin
          first_seen = 1;
          chk("powerup_wait", int'(since >= POWERUP + 1 && since <= POWERUP + 6), 1);
        end
        if (q.size() == 0) begin
          have = 0;
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: got write %0h, expected none", lcd_data);
        end else begin
          cur = q.pop_front();
          have = 1;
          chk("pulse_rs", int'(lcd_rs), int'(cur.rs));
          chk("pulse_data", int'(lcd_data), int'(cur.data));
          chk("pulse_init_done", int'(init_done), int'(!cur.init));
          chk("lcd_rw", int'(lcd_rw), 0);
          exp_lat = 1 + EN + wait_of(cur);
          track = 1;
          rise_at = since;
        end
        in_pulse = 1;
        hi = 1;
      end else if (lcd_en) begin
        hi++;
        if (have) chk("data_stable", int'({lcd_rs, lcd_data}), int'({cur.rs, cur.data}));
      end else if (in_pulse) begin
        in_pulse = 0;
        chk("pulse_len", hi, EN);
      end
      if (track && !busy) begin
        chk("ready_latency", since - rise_at + 1, exp_lat);
        chk("ready_at_idle", int'(req_ready), 1);
        chk("init_done_at_idle", int'(init_done), 1);
        track = 0;
      end
    end
  end

  task automatic push_item(input logic rs, input logic [7:0] d, input bit init);
    item_t it;
    it.rs = rs; it.data = d; it.init = init;
    q.push_back(it);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lcd_en", int'(lcd_en), 0);
    chk("rst_lcd_rs", int'(lcd_rs), 0);
    chk("rst_lcd_rw", int'(lcd_rw), 0);
    chk("rst_lcd_data", int'(lcd_data), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_req_ready", int'(req_ready), 0);
    push_item(1'b0, 8'h38, 1);
    push_item(1'b0, 8'h0C, 1);
    push_item(1'b0, 8'h06, 1);
    push_item(1'b0, 8'h01, 1);
    rst_n = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_req(input logic rs, input logic [7:0] d, input bit keep_valid);
    int n = 0;
    req_rs = rs; req_data = d; req_valid = 1'b1;
    while (!req_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: got no req_ready after %0d cycles, expected ready", n);
    end else begin
      push_item(rs, d, 0);
      @(posedge clk); #1;
      chk("latched_rs", int'(lcd_rs), int'(rs));
      chk("latched_data", int'(lcd_data), int'(d));
    end
    if (!keep_valid) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (busy || q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d, expected idle", busy, q.size());
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    string      word;
    logic       rs;
    logic [7:0] d;
    int         n;

    // Power-up with a request already pending: it must wait for init.
    req_rs = 1'b1; req_data = 8'h5A; req_valid = 1'b1;
    do_reset();
    send_req(1'b1, 8'h5A, 0);
    wait_idle();

    send_req(1'b1, 8'h41, 0);
    wait_idle();
    send_req(1'b0, 8'h01, 0);
    wait_idle();
    send_req(1'b0, 8'h80, 0);
    wait_idle();
    send_req(1'b0, 8'h02, 0);
    wait_idle();

    word = "verilog";
    for (int i = 0; i < word.len(); i++) send_req(1'b1, word[i], 1);
    req_valid = 1'b0;
    wait_idle();

    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rs = 1'b0;
        d  = 8'($urandom_range(1, 2));
      end
      send_req(rs, d, 0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    wait_idle();

    // Reset in the middle of a data write's enable pulse.
    send_req(1'b1, 8'h33, 0);
    n = 0;
    while (!lcd_en && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("pulse_started", int'(lcd_en), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_en", int'(lcd_en), 0);
    chk("async_rst_init_done", int'(init_done), 0);
    chk("async_rst_busy", int'(busy), 1);
    do_reset();
    wait_idle();
    send_req(1'b1, 8'h21, 0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
